// File: rtl/lns_encoder.sv
// lns_encoder
// Sequential linear-to-log2 converter feeding the LNS add/sub datapath.
// A signed sample X is accepted, its magnitude taken, and log2(|X|*2^-IN_FRAC)
// produced as a signed fixed-point Z (LOG_WIDTH bits, FRAC_BITS fractional)
// with a separate sign Sz. The integer part comes from a leading-one search and
// the fraction from iterative squaring of the normalised mantissa, one bit per
// cycle, MSB first.
//
// Optional build macro: LNS_ENC_ROUND_EN -- compute one extra guard bit and
// round half-up (one extra cycle of latency). Undefined: pure truncation.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   X valid
//   in_ready   out  encoder idle, accepts X
//   X          in   IN_WIDTH  linear sample, two's complement
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   Z          out  LOG_WIDTH log2 magnitude, signed fixed point
//   Sz         out  sign of X (1 = negative)
//   zero       out  X was zero; Z holds the LNS zero code (most negative)
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// NORM  | leading-one search, mantissa normalisation, zero detect
// ITER  | one fractional bit per cycle by squaring the mantissa
// DONE  | result presented, held until out_ready

module lns_encoder #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_FRAC   = 0,
  parameter int LOG_WIDTH = 22,
  parameter int FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  X,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG_WIDTH-1:0] Z,
  output logic                 Sz,
  output logic                 zero
);

  localparam int INT_BITS = LOG_WIDTH - FRAC_BITS;
  localparam int MW       = FRAC_BITS + 2;          // mantissa Q1.(FRAC_BITS+1)
  localparam int PW       = $clog2(IN_WIDTH);
`ifdef LNS_ENC_ROUND_EN
  localparam int NBITS    = FRAC_BITS + 1;          // fraction plus guard bit
`else
  localparam int NBITS    = FRAC_BITS;
`endif
  localparam int CW       = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  mag_q;
  logic [MW-1:0]        m_q;
  logic [INT_BITS-1:0]  int_q;
  logic [NBITS-1:0]     frac_q;
  logic [CW-1:0]        cnt_q;
  logic [LOG_WIDTH-1:0] z_q;
  logic                 sz_q;
  logic                 zero_q;

  logic [PW-1:0]        lead;
  logic [IN_WIDTH-1:0]  norm;
  logic [MW-1:0]        m_init;
  logic [INT_BITS-1:0]  int_d;
  logic [2*MW-1:0]      prod;
  logic [MW:0]          m2;
  logic [NBITS-1:0]     frac_next;
  logic [LOG_WIDTH-1:0] z_asm;
  logic                 last_iter;

  // Leading-one search and left-justification of the magnitude.
  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (mag_q[i]) lead = PW'(i);
    end
    norm  = mag_q << (PW'(IN_WIDTH - 1) - lead);
    int_d = INT_BITS'(lead) - INT_BITS'(IN_FRAC);
  end

  // Place the justified magnitude in the mantissa: zero-fill below when the
  // mantissa is wider, drop excess LSBs (truncate) when it is narrower.
  generate
    if (MW >= IN_WIDTH) begin : g_widen
      assign m_init = MW'(norm) << (MW - IN_WIDTH);
    end else begin : g_narrow
      assign m_init = MW'(norm >> (IN_WIDTH - MW));
    end
  endgenerate

  // One squaring step: m*m is Q2.(2*FRAC_BITS+2); keep Q2.(FRAC_BITS+1).
  always_comb begin
    prod      = m_q * m_q;
    m2        = (MW + 1)'(prod >> (FRAC_BITS + 1));
    frac_next = {frac_q[NBITS-2:0], m2[MW]};
    last_iter = (cnt_q == CW'(NBITS - 1));
`ifdef LNS_ENC_ROUND_EN
    // Guard bit adds half an LSB; the carry may ripple into the integer part.
    z_asm     = {int_q, frac_next[NBITS-1:1]} + LOG_WIDTH'(frac_next[0]);
`else
    z_asm     = {int_q, frac_next};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = NORM;
      NORM:    state_d = (mag_q == '0) ? DONE : ITER;
      ITER:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q  <= '0;
      m_q    <= '0;
      int_q  <= '0;
      frac_q <= '0;
      cnt_q  <= '0;
      z_q    <= '0;
      sz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Magnitude kept unsigned so the most negative input stays exact.
            sz_q   <= X[IN_WIDTH-1];
            mag_q  <= X[IN_WIDTH-1] ? (~X + 1'b1) : X;
            zero_q <= 1'b0;
          end
        end
        NORM: begin
          if (mag_q == '0) begin
            zero_q <= 1'b1;
            sz_q   <= 1'b0;
            z_q    <= {1'b1, {(LOG_WIDTH-1){1'b0}}};
          end else begin
            int_q  <= int_d;
            m_q    <= m_init;
            frac_q <= '0;
            cnt_q  <= '0;
          end
        end
        ITER: begin
          m_q    <= m2[MW] ? m2[MW:1] : m2[MW-1:0];
          frac_q <= frac_next;
          cnt_q  <= cnt_q + CW'(1);
          if (last_iter) z_q <= z_asm;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Z         = z_q;
  assign Sz        = sz_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_lns_encoder.sv
module tb_lns_encoder;
  localparam int IW = 16;
  localparam int LW = 22;
  localparam int FB = 16;
`ifdef LNS_ENC_ROUND_EN
  localparam int NB  = FB + 1;
  localparam int LAT = FB + 2;
`else
  localparam int NB  = FB;
  localparam int LAT = FB + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] x;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] z;
  logic          sz;
  logic          zero;

  int errors = 0;
  int checks = 0;

  logic [LW-1:0] last_z;
  logic          last_sz;

  typedef struct {
    logic [LW-1:0] z;
    logic          sz;
    logic          zero;
    int            lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lns_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(x),
    .out_valid(out_valid), .out_ready(out_ready), .Z(z), .Sz(sz), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Bit-accurate model of the squaring algorithm at the default parameters.
  function automatic exp_t model(input logic [IW-1:0] xv);
    exp_t          e;
    logic [IW-1:0] mag;
    int            p;
    logic [17:0]   m;
    logic [35:0]   pr;
    logic [18:0]   m2;
    logic [NB-1:0] fr;
    logic [LW-1:0] t;
    mag    = xv[IW-1] ? (~xv + 1'b1) : xv;
    e.sz   = xv[IW-1];
    e.zero = 1'b0;
    e.lat  = LAT;
    if (mag == '0) begin
      e.z    = {1'b1, {(LW-1){1'b0}}};
      e.sz   = 1'b0;
      e.zero = 1'b1;
      e.lat  = 1;
      return e;
    end
    p = 0;
    for (int i = 0; i < IW; i++) if (mag[i]) p = i;
    m  = {mag << (IW - 1 - p), 2'b00};
    fr = '0;
    for (int k = 0; k < NB; k++) begin
      pr = m * m;
      m2 = pr[35:17];
      fr = {fr[NB-2:0], m2[18]};
      m  = m2[18] ? m2[18:1] : m2[17:0];
    end
    t = LW'(p) << FB;
    t = t + LW'(fr >> (NB - FB));
`ifdef LNS_ENC_ROUND_EN
    t = t + LW'(fr[0]);
`endif
    e.z = t;
    return e;
  endfunction

  task automatic run(input logic [IW-1:0] xv, input int hold);
    exp_t          e;
    int            k;
    logic [IW-1:0] mag;
    real           ideal, d;
    out_ready = (hold == 0);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    x = xv;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(xv));
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < LAT + 10) begin @(negedge clk); k++; end
    e = sb.pop_front();
    check("out_valid_timeout", 32'(out_valid), 32'd1);
    check("latency", 32'(k), 32'(e.lat));
    check("z", 32'(z), 32'(e.z));
    check("sz", 32'(sz), 32'(e.sz));
    check("zero", 32'(zero), 32'(e.zero));
    last_z  = z;
    last_sz = sz;
    mag = xv[IW-1] ? (~xv + 1'b1) : xv;
    if (mag != '0) begin
      ideal = $ln(real'(mag)) / $ln(2.0) * 65536.0;
      d     = $itor($signed(z)) - ideal;
      check("ideal_1lsb", 32'(d > -1.001 && d < 1.001), 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin x = 16'd5; in_valid = 1'b1; end
      if (h == 3) in_valid = 1'b0;
      @(negedge clk);
      check("hold_z", 32'(z), 32'(e.z));
      check("hold_sz", 32'(sz), 32'(e.sz));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_sz", 32'(sz), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    run(16'd1, 0);
    check("x1_const", 32'(last_z), 32'h000000);
    run(-16'sd8, 0);
    check("xm8_const", 32'(last_z), 32'h030000);
    check("xm8_sign", 32'(last_sz), 32'd1);
    run(16'd3, 0);
    run(16'd0, 0);
    check("x0_const", 32'(last_z), 32'h200000);
    run(16'h8000, 5);
    check("xmin_const", 32'(last_z), 32'h0F0000);
    check("xmin_sign", 32'(last_sz), 32'd1);
    run(16'd7, 0);
    run(16'd5, 0);
    run(16'hFFFF, 0);
    run(16'h7FFF, 0);
    run(16'd100, 0);
    run(-16'sd12345, 0);
    for (int r = 0; r < 3; r++) run(16'($urandom), 0);

    // Reset in the middle of ITER: result discarded, no out_valid pulse.
    @(negedge clk);
    x = 16'd1234; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_z", 32'(z), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    check("no_pulse_after_rst", 32'(k), 32'd0);
    run(16'd16, 0);
    check("x16_const", 32'(last_z), 32'h040000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
